// File: rtl/minmax_window_tracker_pkg.sv
// +--------------------------------------------------------------------+
// | Module  : minmax_window_tracker_pkg                                |
// | Brief   : FSM state encoding and default sizes for the tracker.    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package minmax_window_tracker_pkg;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int C_DEF_DATA_W  = 4;
  localparam int C_DEF_WIN_LEN = 8;
  localparam int C_DEF_IDX_W   = 3;

endpackage

`default_nettype wire

// File: rtl/minmax_window_tracker_nibble_compare.sv
// +--------------------------------------------------------------------+
// | Module  : nibble_compare                                           |
// | Brief   : DATA_W-bit eq/gt/lt compare; signed when                 |
// |           MINMAX_SIGNED_CMP_EN is defined, unsigned otherwise.     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module nibble_compare
  import minmax_window_tracker_pkg::*;
#(
  parameter int DATA_W = C_DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_eq,
  output logic              o_gt,
  output logic              o_lt
);

  assign o_eq = (i_a == i_b);
`ifdef MINMAX_SIGNED_CMP_EN
  assign o_gt = ($signed(i_a) > $signed(i_b));
  assign o_lt = ($signed(i_a) < $signed(i_b));
`else
  assign o_gt = (i_a > i_b);
  assign o_lt = (i_a < i_b);
`endif

endmodule

`default_nettype wire

// File: rtl/minmax_window_tracker.sv
// +--------------------------------------------------------------------+
// | Module  : minmax_window_tracker                                    |
// | Brief   : Per-window running max/min with first-occurrence index,  |
// |           valid/ready in and out. Signed compare via macro         |
// |           MINMAX_SIGNED_CMP_EN (unsigned when undefined).          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module minmax_window_tracker
  import minmax_window_tracker_pkg::*;
#(
  parameter int DATA_W  = C_DEF_DATA_W,
  parameter int WIN_LEN = C_DEF_WIN_LEN,
  parameter int IDX_W   = C_DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [IDX_W-1:0]  out_max_idx,
  output logic [IDX_W-1:0]  out_min_idx
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_max;
  logic [DATA_W-1:0]  r_min;
  logic [IDX_W-1:0]   r_max_idx;
  logic [IDX_W-1:0]   r_min_idx;
  logic               w_accept;
  logic               w_last;
  logic               w_max_eq, w_max_gt, w_max_lt;
  logic               w_min_eq, w_min_gt, w_min_lt;

  nibble_compare #(.DATA_W(DATA_W)) u_cmp_max (
    .i_a (in_data),
    .i_b (r_max),
    .o_eq(w_max_eq),
    .o_gt(w_max_gt),
    .o_lt(w_max_lt)
  );

  nibble_compare #(.DATA_W(DATA_W)) u_cmp_min (
    .i_a (in_data),
    .i_b (r_min),
    .o_eq(w_min_eq),
    .o_gt(w_min_gt),
    .o_lt(w_min_lt)
  );

  // clr wins over a simultaneous sample; S_HOLD never accepts anyway
  assign w_accept = in_valid && (r_state != S_HOLD) && !clr;
  assign w_last   = (r_cnt == IDX_W'(WIN_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    case (r_state)
      S_FIRST: begin
        if (w_accept) begin
          w_state_nxt = (WIN_LEN == 1) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (clr) begin
          w_state_nxt = S_FIRST;
        end else if (w_accept && w_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_FIRST;
        end
      end
      default: w_state_nxt = S_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
    end else if (clr && (r_state != S_HOLD)) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == S_FIRST) begin
        r_max     <= in_data;
        r_min     <= in_data;
        r_max_idx <= '0;
        r_min_idx <= '0;
        r_cnt     <= (WIN_LEN == 1) ? '0 : IDX_W'(1);
      end else begin
        // Only a strict improvement moves the index, so ties keep the first one
        case ({w_max_gt, w_max_eq, w_max_lt})
          3'b100: begin
            r_max     <= in_data;
            r_max_idx <= r_cnt;
          end
          default: ;
        endcase
        case ({w_min_gt, w_min_eq, w_min_lt})
          3'b001: begin
            r_min     <= in_data;
            r_min_idx <= r_cnt;
          end
          default: ;
        endcase
        r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
      end
    end
  end

  assign out_max     = r_max;
  assign out_min     = r_min;
  assign out_max_idx = r_max_idx;
  assign out_min_idx = r_min_idx;

endmodule

`default_nettype wire

// File: tb/tb_minmax_window_tracker.sv
// +--------------------------------------------------------------------+
// | Module  : tb_minmax_window_tracker                                 |
// | Brief   : Scoreboard bench for minmax_window_tracker, WIN_LEN=4.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_minmax_window_tracker;

  localparam int DATA_W  = 4;
  localparam int WIN_LEN = 4;
  localparam int IDX_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] mn;
    logic [IDX_W-1:0]  mxi;
    logic [IDX_W-1:0]  mni;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_min;
  logic [IDX_W-1:0]  out_max_idx;
  logic [IDX_W-1:0]  out_min_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] m_win[$];
  res_t              exp_q[$];
  bit                m_hold = 1'b0;

  minmax_window_tracker #(
    .DATA_W (DATA_W),
    .WIN_LEN(WIN_LEN),
    .IDX_W  (IDX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
    .out_max_idx(out_max_idx),
    .out_min_idx(out_min_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MINMAX_SIGNED_CMP_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic res_t model_window();
    res_t r;
    r.mx = m_win[0]; r.mxi = '0;
    r.mn = m_win[0]; r.mni = '0;
    for (int i = 1; i < WIN_LEN; i++) begin
      if (greater(m_win[i], r.mx)) begin r.mx = m_win[i]; r.mxi = IDX_W'(i); end
      if (greater(r.mn, m_win[i])) begin r.mn = m_win[i]; r.mni = IDX_W'(i); end
    end
    return r;
  endfunction

  // One clock of stimulus; the model predicts the effect of the next rising edge
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit c, input bit r);
    @(negedge clk);
    in_valid = v; in_data = d; clr = c; out_ready = r;
    #2;
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("in_ready", int'(in_ready), int'(!m_hold));
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else if (c) begin
      m_win.delete();
    end else if (v) begin
      m_win.push_back(d);
      if (m_win.size() == WIN_LEN) begin
        exp_q.push_back(model_window());
        m_win.delete();
        m_hold = 1'b1;
      end
    end
  endtask

  task automatic send4(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    cycle(1, a, 0, 1); cycle(1, b, 0, 1); cycle(1, c, 0, 1); cycle(1, d, 0, 1);
    cycle(0, 0, 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_max"}, int'(out_max), 0);
    chk({tag, "_out_min"}, int'(out_min), 0);
    chk({tag, "_out_max_idx"}, int'(out_max_idx), 0);
    chk({tag, "_out_min_idx"}, int'(out_min_idx), 0);
  endtask

  // Monitor: compares the head result while presented, pops on transfer
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("out_max", int'(out_max), int'(exp_q[0].mx));
        chk("out_max_idx", int'(out_max_idx), int'(exp_q[0].mxi));
        chk("out_min", int'(out_min), int'(exp_q[0].mn));
        chk("out_min_idx", int'(out_min_idx), int'(exp_q[0].mni));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send4(4'd3, 4'd9, 4'd1, 4'd9);
    send4(4'd5, 4'd5, 4'd5, 4'd5);

    // Backpressure with a sample waiting behind the held result
    cycle(1, 4'd3, 0, 0); cycle(1, 4'd9, 0, 0); cycle(1, 4'd1, 0, 0); cycle(1, 4'd9, 0, 0);
    repeat (3) cycle(1, 4'd7, 0, 0);
    cycle(1, 4'd7, 0, 1);
    cycle(1, 4'd7, 0, 1); cycle(1, 4'd2, 0, 1); cycle(1, 4'd3, 0, 1); cycle(1, 4'd4, 0, 1);
    cycle(0, 0, 0, 1);

    // Abort mid-window; the sample presented with clr is dropped
    cycle(1, 4'd8, 0, 1); cycle(1, 4'd2, 0, 1); cycle(1, 4'd6, 1, 1);
    send4(4'd0, 4'd15, 4'd7, 4'd2);

    // Asynchronous reset mid-window
    cycle(1, 4'd1, 0, 1); cycle(1, 4'd2, 0, 1); cycle(1, 4'd3, 0, 1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    m_win.delete(); exp_q.delete(); m_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send4(4'd4, 4'd4, 4'd6, 4'd1);

    send4(4'b1000, 4'b0111, 4'b0000, 4'b1111);

    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(99, 0) < 75), DATA_W'($urandom_range(15, 0)),
            ($urandom_range(99, 0) < 5), ($urandom_range(99, 0) < 60));
    end

    repeat (20) cycle(0, 0, 0, 1);
    #5;
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
